cdb_rr_arbiter: RTL and testbench

CDB_RR_ARBITER -- requirements
Module: cdb_rr_arbiter

---
 rtl/cdb_rr_arbiter_pkg.sv | 15 +
 rtl/cdb_rr_arbiter_result_fifo.sv | 66 ++++++
 rtl/cdb_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_cdb_rr_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared result-bus definitions used by the reservation stations and the CDB arbiter.
// The tag MSB marks a live tag; the remaining bits name the producing station entry.
package cdb_rr_arbiter_pkg;

  localparam int CDB_TAG_W   = 8;
  localparam int CDB_DATA_W  = 32;
  localparam int CDB_TAG_VLD = CDB_TAG_W - 1;

  // Two tags match only when both are live and carry the same producer id.
  function automatic logic tag_match(input logic [CDB_TAG_W-1:0] a,
                                     input logic [CDB_TAG_W-1:0] b);
    return a[CDB_TAG_VLD] && b[CDB_TAG_VLD] && (a == b);
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter_result_fifo.sv
// Per-producer result buffer: a small FIFO holding tag/data pairs until a CDB lane is granted.
// Readiness is taken from registered occupancy only, so a pop never frees a slot in the same cycle.
module result_fifo
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int DATA_W    = CDB_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_push,
  input  logic [TAG_W-1:0]            i_tag,
  input  logic [DATA_W-1:0]           i_data,
  input  logic                        i_pop,
  output logic [TAG_W-1:0]            o_tag,
  output logic [DATA_W-1:0]           o_data,
  output logic [$clog2(BUF_DEPTH):0]  o_count,
  output logic                        o_ready,
  output logic                        o_empty
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [TAG_W-1:0]  r_tagMem  [BUF_DEPTH];
  logic [DATA_W-1:0] r_dataMem [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [OCC_W-1:0]  r_count;
  logic              w_doPush;
  logic              w_doPop;

  assign o_ready  = (r_count < OCC_W'(BUF_DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && o_ready;
  assign w_doPop  = i_pop && !o_empty;
  assign o_tag    = r_tagMem[r_rdPtr];
  assign o_data   = r_dataMem[r_rdPtr];
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read once occupancy says it was written.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_tagMem[r_wrPtr]  <= i_tag;
      r_dataMem[r_wrPtr] <= i_data;
    end
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common data bus arbiter: buffers results from each producer and broadcasts up to
// NUM_BUS of them per cycle on registered lanes, granting sources in round-robin order.
module cdb_rr_arbiter
  import cdb_rr_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 3,
  parameter int NUM_BUS   = 2,
  parameter int BUF_DEPTH = 2,
  parameter int TAG_W     = CDB_TAG_W,
  parameter int DATA_W    = CDB_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_BUS*TAG_W-1:0]  cdb_tag,
  output logic [NUM_BUS*DATA_W-1:0] cdb_data,
  output logic                      dispatch_stall,
  output logic                      overflow_err
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int CNT_W = $clog2(NUM_BUS + 1);
  localparam int TOT_W = $clog2(NUM_SRC * BUF_DEPTH + 1);
  localparam logic [SRC_W:0]   NUM_SRC_L = (SRC_W + 1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] NUM_BUS_L = CNT_W'(NUM_BUS);

  logic [TAG_W-1:0]  w_fifoTag   [NUM_SRC];
  logic [DATA_W-1:0] w_fifoData  [NUM_SRC];
  logic [OCC_W-1:0]  w_fifoCount [NUM_SRC];
  logic [NUM_SRC-1:0] w_fifoEmpty;
  logic [NUM_SRC-1:0] w_valid;
  logic [NUM_SRC-1:0] w_pop;

  logic [TAG_W-1:0]  w_laneTag  [NUM_BUS];
  logic [DATA_W-1:0] w_laneData [NUM_BUS];
  logic [SRC_W:0]    w_scanSum;
  logic [SRC_W-1:0]  w_scanIdx;
  logic [CNT_W-1:0]  w_grantCnt;
  logic              w_anyGrant;
  logic [SRC_W-1:0]  w_lastIdx;
  logic [SRC_W:0]    w_nextSum;
  logic [SRC_W-1:0]  w_nextPtr;
  logic [TOT_W-1:0]  w_occTotal;
  logic              w_nearFull;

  logic [SRC_W-1:0]          r_rrPtr;
  logic [NUM_BUS*TAG_W-1:0]  r_cdbTag;
  logic [NUM_BUS*DATA_W-1:0] r_cdbData;
  logic                      r_overflow;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign w_valid[gi] = src_tag[gi*TAG_W + TAG_W - 1];

    result_fifo #(
      .BUF_DEPTH (BUF_DEPTH),
      .TAG_W     (TAG_W),
      .DATA_W    (DATA_W)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_valid[gi]),
      .i_tag   (src_tag[gi*TAG_W +: TAG_W]),
      .i_data  (src_data[gi*DATA_W +: DATA_W]),
      .i_pop   (w_pop[gi]),
      .o_tag   (w_fifoTag[gi]),
      .o_data  (w_fifoData[gi]),
      .o_count (w_fifoCount[gi]),
      .o_ready (src_ready[gi]),
      .o_empty (w_fifoEmpty[gi])
    );
  end

  // Scan sources starting at the round-robin pointer; the k-th non-empty buffer found feeds lane k.
  always_comb begin
    w_pop      = '0;
    w_anyGrant = 1'b0;
    w_lastIdx  = r_rrPtr;
    w_grantCnt = '0;
    w_scanSum  = '0;
    w_scanIdx  = '0;
    for (int l = 0; l < NUM_BUS; l++) begin
      w_laneTag[l]  = '0;
      w_laneData[l] = '0;
    end
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scanSum = {1'b0, r_rrPtr} + (SRC_W + 1)'(k);
      if (w_scanSum >= NUM_SRC_L) w_scanSum = w_scanSum - NUM_SRC_L;
      w_scanIdx = w_scanSum[SRC_W-1:0];
      if (en && !w_fifoEmpty[w_scanIdx] && (w_grantCnt < NUM_BUS_L)) begin
        w_pop[w_scanIdx] = 1'b1;
        for (int l = 0; l < NUM_BUS; l++) begin
          if (w_grantCnt == CNT_W'(l)) begin
            w_laneTag[l]  = w_fifoTag[w_scanIdx];
            w_laneData[l] = w_fifoData[w_scanIdx];
          end
        end
        w_grantCnt = w_grantCnt + CNT_W'(1);
        w_anyGrant = 1'b1;
        w_lastIdx  = w_scanIdx;
      end
    end
    w_nextSum = {1'b0, w_lastIdx} + (SRC_W + 1)'(1);
    w_nextPtr = (w_nextSum >= NUM_SRC_L) ? '0 : w_nextSum[SRC_W-1:0];
  end

  always_comb begin
    w_occTotal = '0;
    w_nearFull = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_occTotal = w_occTotal + TOT_W'(w_fifoCount[i]);
      if (w_fifoCount[i] >= OCC_W'(BUF_DEPTH - 1)) w_nearFull = 1'b1;
    end
  end

  assign dispatch_stall = w_nearFull || (w_occTotal > TOT_W'(NUM_BUS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rrPtr    <= '0;
      r_cdbTag   <= '0;
      r_cdbData  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_anyGrant) r_rrPtr <= w_nextPtr;
      for (int l = 0; l < NUM_BUS; l++) begin
        r_cdbTag[l*TAG_W +: TAG_W]    <= w_laneTag[l];
        r_cdbData[l*DATA_W +: DATA_W] <= w_laneData[l];
      end
      if (|(w_valid & ~src_ready)) r_overflow <= 1'b1;
    end
  end

  assign cdb_tag      = r_cdbTag;
  assign cdb_data     = r_cdbData;
  assign overflow_err = r_overflow;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Scoreboard bench for cdb_rr_arbiter: a queue-based reference model predicts each broadcast,
// and an independent monitor matches what appears on the CDB lanes against those predictions.
module tb_cdb_rr_arbiter;

  localparam int NUM_SRC   = 3;
  localparam int NUM_BUS   = 2;
  localparam int BUF_DEPTH = 2;
  localparam int TAG_W     = 8;
  localparam int DATA_W    = 32;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      en;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_BUS*TAG_W-1:0]  cdb_tag;
  logic [NUM_BUS*DATA_W-1:0] cdb_data;
  logic                      dispatch_stall;
  logic                      overflow_err;

  typedef struct {
    int                        cyc;
    logic [NUM_BUS*TAG_W-1:0]  tag;
    logic [NUM_BUS*DATA_W-1:0] data;
  } exp_t;

  exp_t expQ[$];
  logic [TAG_W+DATA_W-1:0] mq[NUM_SRC][$];
  int   mRr;
  bit   mOvf;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  cdb_rr_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .NUM_BUS   (NUM_BUS),
    .BUF_DEPTH (BUF_DEPTH),
    .TAG_W     (TAG_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .src_tag        (src_tag),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .dispatch_stall (dispatch_stall),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic compare(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    expQ.delete();
    mRr  = 0;
    mOvf = 1'b0;
  endtask

  // Predicts the effect of the coming rising edge from queue contents before that edge.
  task automatic modelStep(input logic enV,
                           input logic [NUM_SRC*TAG_W-1:0] t,
                           input logic [NUM_SRC*DATA_W-1:0] d);
    exp_t e;
    int   granted = 0;
    int   last    = 0;
    bit   rdy[NUM_SRC];
    logic [TAG_W+DATA_W-1:0] ent;
    for (int i = 0; i < NUM_SRC; i++) rdy[i] = (mq[i].size() < BUF_DEPTH);
    e.cyc  = cyc + 1;
    e.tag  = '0;
    e.data = '0;
    if (enV) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        int s;
        s = (mRr + k) % NUM_SRC;
        if (mq[s].size() > 0 && granted < NUM_BUS) begin
          ent = mq[s].pop_front();
          e.tag[granted*TAG_W +: TAG_W]    = ent[TAG_W+DATA_W-1 -: TAG_W];
          e.data[granted*DATA_W +: DATA_W] = ent[DATA_W-1:0];
          granted++;
          last = s;
        end
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (t[i*TAG_W + TAG_W - 1]) begin
        if (rdy[i]) mq[i].push_back({t[i*TAG_W +: TAG_W], d[i*DATA_W +: DATA_W]});
        else        mOvf = 1'b1;
      end
    end
    if (granted > 0) begin
      mRr = (last + 1) % NUM_SRC;
      expQ.push_back(e);
    end
  endtask

  task automatic checkOutput();
    logic [NUM_SRC-1:0] rdyExp;
    int  occTot;
    bit  stallExp;
    occTot   = 0;
    stallExp = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rdyExp[i] = (mq[i].size() < BUF_DEPTH);
      occTot   += mq[i].size();
      if (mq[i].size() >= BUF_DEPTH - 1) stallExp = 1'b1;
    end
    if (occTot > NUM_BUS) stallExp = 1'b1;
    compare("src_ready", 64'(src_ready), 64'(rdyExp));
    compare("dispatch_stall", 64'(dispatch_stall), 64'(stallExp));
    compare("overflow_err", 64'(overflow_err), 64'(mOvf));
  endtask

  // Drives one cycle of inputs, predicts its outcome, then checks the status outputs.
  task automatic applyStimulus(input logic enV,
                               input logic [NUM_SRC*TAG_W-1:0] t,
                               input logic [NUM_SRC*DATA_W-1:0] d);
    en       = enV;
    src_tag  = t;
    src_data = d;
    modelStep(enV, t, d);
    @(negedge clk);
    checkOutput();
  endtask

  // Monitor: any live lane tag consumes the oldest prediction, which must be due this cycle.
  always @(negedge clk) begin
    if (!reset) begin
      bit dutAny;
      exp_t e;
      dutAny = 1'b0;
      for (int l = 0; l < NUM_BUS; l++) if (cdb_tag[l*TAG_W + TAG_W - 1]) dutAny = 1'b1;
      if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        e = expQ.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL stale_broadcast: due cycle %0d still pending at cycle %0d tag=%h", e.cyc, cyc, e.tag);
      end
      if (dutAny) begin
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_broadcast: got tag=%h data=%h expected nothing (cycle %0d)", cdb_tag, cdb_data, cyc);
        end else begin
          e = expQ.pop_front();
          if (e.cyc != cyc || cdb_tag !== e.tag || cdb_data !== e.data) begin
            bad++;
            $display("[TB] FAIL broadcast: got cyc=%0d tag=%h data=%h expected cyc=%0d tag=%h data=%h",
                     cyc, cdb_tag, cdb_data, e.cyc, e.tag, e.data);
          end
        end
      end else if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL missing_broadcast: got tag=%h expected tag=%h data=%h (cycle %0d)", cdb_tag, e.tag, e.data, cyc);
      end
    end
  end

  function automatic logic [NUM_SRC*TAG_W-1:0] idleTags();
    return '0;
  endfunction

  initial begin
    logic [NUM_SRC*TAG_W-1:0]  t;
    logic [NUM_SRC*DATA_W-1:0] d;
    logic [TAG_W-1:0]          tg;

    reset    = 1'b1;
    en       = 1'b0;
    src_tag  = '0;
    src_data = '0;
    modelClear();
    repeat (2) @(negedge clk);
    checkOutput();
    compare("reset_cdb_tag", 64'(cdb_tag), 64'h0);
    compare("reset_cdb_data", 64'(cdb_data), 64'h0);

    $display("[TB] three simultaneous pushes, round-robin from source 0");
    reset = 1'b0;
    applyStimulus(1'b1, {8'h83, 8'h82, 8'h81}, {32'h3333, 32'h2222, 32'h1111});
    applyStimulus(1'b1, idleTags(), '0);
    applyStimulus(1'b1, idleTags(), '0);
    applyStimulus(1'b1, idleTags(), '0);

    $display("[TB] single push on source 1");
    applyStimulus(1'b1, {8'h00, 8'h85, 8'h00}, {32'h0, 32'h1234, 32'h0});
    applyStimulus(1'b1, idleTags(), '0);
    applyStimulus(1'b1, idleTags(), '0);

    $display("[TB] arbitration disabled while source 2 fills");
    applyStimulus(1'b0, {8'h90, 8'h00, 8'h00}, {32'hA0, 32'h0, 32'h0});
    applyStimulus(1'b0, {8'h91, 8'h00, 8'h00}, {32'hA1, 32'h0, 32'h0});
    applyStimulus(1'b0, {8'h11, 8'h22, 8'h33}, '1);
    applyStimulus(1'b1, idleTags(), '0);
    applyStimulus(1'b1, idleTags(), '0);
    applyStimulus(1'b1, idleTags(), '0);

    $display("[TB] source 0 pushes into a full buffer");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, {8'h00, 8'h00, 8'hC0 | 8'(i)}, {32'h0, 32'h0, 32'hBEEF0000 | 32'(i)});

    $display("[TB] asynchronous reset with buffers occupied");
    applyStimulus(1'b0, {8'hD2, 8'h00, 8'h00}, {32'hD2D2, 32'h0, 32'h0});
    applyStimulus(1'b1, idleTags(), '0);
    #2;
    reset = 1'b1;
    modelClear();
    #1;
    compare("midreset_cdb_tag", 64'(cdb_tag), 64'h0);
    compare("midreset_cdb_data", 64'(cdb_data), 64'h0);
    checkOutput();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, {8'h00, 8'h00, 8'hE7}, {32'h0, 32'h0, 32'h0E0E});
    applyStimulus(1'b1, idleTags(), '0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        tg = TAG_W'($urandom);
        tg[TAG_W-1] = ($urandom_range(0, 99) < 40);
        t[i*TAG_W +: TAG_W]   = tg;
        d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      applyStimulus($urandom_range(0, 9) < 7, t, d);
    end

    for (int n = 0; n < 8; n++) applyStimulus(1'b1, idleTags(), '0);
    compare("drain_pending", 64'(expQ.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
